// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory path: access size codes,
// sequencer states and the size-to-byte-count helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_LAST,
        ST_DONE
    } seq_state_e;

    // Reserved size code 2'b11 is handled as a full word.
    function automatic logic [2:0] bytes_per_size(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load word.
// Shared with the core load path, so it stays purely combinational.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    // Widen byte/half results; words (and the reserved code) pass through.
    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & word_i[7]}}, word_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & word_i[15]}}, word_i[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/ram_word_sequencer.sv
// Breaks one 32-bit load/store into single-byte accesses on a byte-wide
// synchronous RAM (1-cycle read latency), little-endian, with load extension.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for a request; RAM port quiet
// ST_WR      | presenting one write byte per cycle, base+0 .. base+N-1
// ST_RD      | presenting read addresses; collecting the byte from last cycle
// ST_RD_LAST | no new address; collecting the final byte, updating rdata_o
// ST_DONE    | one-cycle done_o pulse, not ready
module ram_word_sequencer
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [31:0]           wdata_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [31:0]           rdata_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [7:0]            ram_din_o,
    output logic                  ram_we_o,
    input  logic [7:0]            ram_dout_i
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(1);

    seq_state_e  state;
    logic [1:0]  cnt;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [23:0] wdata_q;
    logic [31:0] asm_q;

    logic [2:0]  n_bytes;
    logic [1:0]  last_idx;
    logic [1:0]  slot;
    logic [31:0] asm_merged;
    logic [31:0] ext_word;
    logic        unused_bits;

    assign n_bytes  = bytes_per_size(size_q);
    assign last_idx = n_bytes[1:0] - 2'd1;

    // Upper request address bits are outside the attached RAM and dropped.
    assign unused_bits = ^{addr_i[31:ADDR_WIDTH], n_bytes[2]};

    // RAM data lags the address by one cycle, so in ST_RD the byte arriving
    // now belongs to the previous counter value.
    assign slot = (state == ST_RD_LAST) ? cnt : cnt - 2'd1;

    // Merge the byte currently on ram_dout_i into the assembly word.
    always_comb begin
        asm_merged = asm_q;
        asm_merged[8*slot +: 8] = ram_dout_i;
    end

    mem_load_ext u_load_ext (
        .word_i     (asm_merged),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .data_o     (ext_word)
    );

    // Sequencer FSM; every RAM-side output is registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            cnt        <= 2'd0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            asm_q      <= '0;
            ready_o    <= 1'b1;
            done_o     <= 1'b0;
            rdata_o    <= '0;
            ram_addr_o <= '0;
            ram_din_o  <= '0;
            ram_we_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        cnt        <= 2'd0;
                        size_q     <= size_i;
                        unsigned_q <= unsigned_i;
                        asm_q      <= '0;
                        ready_o    <= 1'b0;
                        ram_addr_o <= addr_i[ADDR_WIDTH-1:0];
                        if (we_i) begin
                            // First byte goes out in the cycle right after acceptance.
                            ram_we_o  <= 1'b1;
                            ram_din_o <= wdata_i[7:0];
                            wdata_q   <= wdata_i[31:8];
                            state     <= ST_WR;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_WR: begin
                    if (cnt == last_idx) begin
                        ram_we_o <= 1'b0;
                        done_o   <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt        <= cnt + 2'd1;
                        ram_addr_o <= ram_addr_o + ADDR_INC;
                        ram_din_o  <= wdata_q[7:0];
                        wdata_q    <= {8'h00, wdata_q[23:8]};
                    end
                end
                ST_RD: begin
                    if (cnt != 2'd0) begin
                        asm_q <= asm_merged;
                    end
                    if (cnt == last_idx) begin
                        state <= ST_RD_LAST;
                    end else begin
                        cnt        <= cnt + 2'd1;
                        ram_addr_o <= ram_addr_o + ADDR_INC;
                    end
                end
                ST_RD_LAST: begin
                    asm_q   <= asm_merged;
                    rdata_o <= ext_word;
                    done_o  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done_o  <= 1'b0;
                    ready_o <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: begin
                    ram_we_o <= 1'b0;
                    done_o   <= 1'b0;
                    ready_o  <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_word_sequencer.sv
// Scoreboard bench for ram_word_sequencer with a behavioural byte RAM.
module tb_ram_word_sequencer;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [11:0] ram_addr_o;
    logic [7:0]  ram_din_o;
    logic        ram_we_o;
    logic [7:0]  ram_dout_i;

    ram_word_sequencer #(.ADDR_WIDTH(12)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .wdata_i    (wdata_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .ram_addr_o (ram_addr_o),
        .ram_din_o  (ram_din_o),
        .ram_we_o   (ram_we_o),
        .ram_dout_i (ram_dout_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:4095];

    // Byte RAM: synchronous write, registered read.
    always @(posedge clk_i) begin
        if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
        ram_dout_i <= mem[ram_addr_o];
    end

    typedef struct { int lat; logic [31:0] rdata; } exp_t;
    typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    exp_t e;
    wr_t  w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int acc_cnt = 0;
    int last_done_cyc = 0;
    bit run = 0;
    bit done_prev = 0;
    logic [31:0] last_load = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle count and acceptance timestamp (acceptance edge = cycle 0).
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_ni && req_i && ready_o) begin
            acc_cyc <= cyc;
            acc_cnt <= acc_cnt + 1;
        end
    end

    // Output monitor: pops write and completion expectations.
    always @(negedge clk_i) begin
        if (rst_ni && run) begin
            if (ram_we_o) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", 32'(ram_addr_o), 32'(w.a));
                    chk("wr_data", 32'(ram_din_o), 32'(w.d));
                end
                chk("ready_busy", 32'(ready_o), 0);
            end
            if (done_o) begin
                last_done_cyc = cyc;
                if (done_prev) chk("done_width", 1, 0);
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_lat", 32'(cyc - acc_cyc), 32'(e.lat));
                    chk("rdata", rdata_o, e.rdata);
                end
                chk("ready_in_done", 32'(ready_o), 0);
                chk("we_in_done", 32'(ram_we_o), 0);
            end
            done_prev = done_o;
        end
    end

    // Drive a request (called at a negedge) and return after it is accepted.
    task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd);
        int   n0;
        int   nb;
        exp_t ex;
        wr_t  wx;
        n0 = acc_cnt;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        req_i = 1'b1; we_i = we; addr_i = a; size_i = sz; unsigned_i = uns; wdata_i = wd;
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                wx.a = 12'(a + 32'(k));
                wx.d = 8'(wd >> (8 * k));
                wr_q.push_back(wx);
            end
            ex.lat = nb + 1;
            ex.rdata = last_load;
        end else begin
            ex.lat = nb + 2;
            ex.rdata = exp_rd;
            last_load = exp_rd;
        end
        exp_q.push_back(ex);
        for (int i = 0; i < 40 && acc_cnt == n0; i++) @(negedge clk_i);
        if (acc_cnt == n0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            chk("done_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        chk("wr_left", 32'(wr_q.size()), 0);
        wr_q.delete();
        @(negedge clk_i);
    endtask

    task automatic single(input logic we, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd);
        issue(we, a, sz, uns, wd, exp_rd);
        req_i = 1'b0;
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h80;
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
        size_i = 2'b00; unsigned_i = 1'b0; wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_we", 32'(ram_we_o), 0);
        chk("rst_addr", 32'(ram_addr_o), 0);
        chk("rst_din", 32'(ram_din_o), 0);
        rst_ni = 1'b1;
        run = 1'b1;
        @(negedge clk_i);

        // Word store then word load, bytes EF BE AD DE at 0x100..0x103.
        single(1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0);
        single(1'b0, 32'hFFFF_F100, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF);
        // Byte load of 0x80, signed and unsigned.
        single(1'b0, 32'h0000_0200, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80);
        single(1'b0, 32'h0000_0200, 2'b00, 1'b1, 32'h0, 32'h0000_0080);
        // Half store across the top of the address space, then loads.
        single(1'b1, 32'h0000_0FFF, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0);
        chk("wrap_lo", 32'(mem[12'hFFF]), 32'h0000_00CD);
        chk("wrap_hi", 32'(mem[12'h000]), 32'h0000_00AB);
        single(1'b0, 32'h0000_0FFF, 2'b01, 1'b0, 32'h0, 32'hFFFF_ABCD);
        single(1'b0, 32'h0000_0FFF, 2'b01, 1'b1, 32'h0, 32'h0000_ABCD);
        // Reserved size code behaves as word.
        single(1'b0, 32'h0000_0100, 2'b11, 1'b1, 32'h0, 32'hDEAD_BEEF);

        // Back-to-back with req_i held: store byte then load it.
        issue(1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'h0000_005A, 32'h0);
        issue(1'b0, 32'h0000_0010, 2'b00, 1'b1, 32'h0, 32'h0000_005A);
        chk("b2b_gap", 32'(acc_cyc - last_done_cyc), 1);
        req_i = 1'b0;
        wait_done();

        // Reset in cycle 2 of a word store.
        issue(1'b1, 32'h0000_0300, 2'b10, 1'b0, 32'h4433_2211, 32'h0);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        req_i = 1'b0;
        #1;
        chk("arst_we", 32'(ram_we_o), 0);
        chk("arst_ready", 32'(ready_o), 1);
        chk("arst_done", 32'(done_o), 0);
        chk("arst_rdata", rdata_o, 0);
        chk("arst_wr_pending", 32'(wr_q.size()), 2);
        wr_q.delete();
        chk("arst_done_pending", 32'(exp_q.size()), 1);
        exp_q.delete();
        last_load = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        chk("arst_b0", 32'(mem[12'h300]), 32'h0000_0011);
        chk("arst_b2", 32'(mem[12'h302]), 0);
        chk("arst_b3", 32'(mem[12'h303]), 0);
        single(1'b0, 32'h0000_0300, 2'b00, 1'b1, 32'h0, 32'h0000_0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
